// File: rtl/clk_div_sched_pkg.sv
// Shared definitions for the divided-clock scheduler: default widths, the
// config FSM state type, and the counter-phase helpers shared by the top
// level and the per-channel dividers.
package clk_div_sched_pkg;

  // Default ratio-select width; the prescaler is one bit narrower than 2^SELW
  // so that select value s (1..CNTW) always names an existing counter bit.
  localparam int SELW = 3;
  localparam int CNTW = (1 << SELW) - 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } cfg_state_t;

  // Low 'sel' bits of the counter, i.e. the phase within a 2^sel period.
  // Arguments are 32 bits wide so any module parameterisation can share
  // these helpers.
  function automatic logic [31:0] phase_bits(input logic [31:0] cnt,
                                             input int unsigned sel);
    logic [31:0] mask;
    mask = (32'd1 << sel) - 32'd1;
    return cnt & mask;
  endfunction

  // True at the start of a 2^sel period (phase zero). sel = 0 is always a
  // boundary because an idle channel has no phase to protect.
  function automatic logic period_start(input logic [31:0] cnt,
                                        input int unsigned sel);
    return phase_bits(cnt, sel) == 32'd0;
  endfunction

  // True on the first count of the high half of a 2^sel period, which is
  // where the enable strobe sits.
  function automatic logic boundary_match(input logic [31:0] cnt,
                                          input int unsigned sel);
    if (sel == 0) begin
      return 1'b0;
    end
    return phase_bits(cnt, sel) == (32'd1 << (sel - 1));
  endfunction

  // Divided level for ratio 2^sel: counter bit sel-1.
  function automatic logic level_bit(input logic [31:0] cnt,
                                     input int unsigned sel);
    logic [31:0] shifted;
    if (sel == 0) begin
      return 1'b0;
    end
    shifted = cnt >> (sel - 1);
    return shifted[0];
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One output channel: holds its ratio select and produces the registered
// divided level and enable strobe from the shared next-count value.
module clk_div_chan
  import clk_div_sched_pkg::*;
#(
  parameter int SELW = clk_div_sched_pkg::SELW,
  parameter int CNTW = (1 << SELW) - 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [CNTW-1:0] cnt_nxt,
  input  logic            run,
  input  logic            sync_clr,
  input  logic            load,
  input  logic [SELW-1:0] load_sel,
  output logic [SELW-1:0] sel,
  output logic            div_clk,
  output logic            en_out
);

  logic [SELW-1:0] sel_reg;
  logic [SELW-1:0] sel_next;
  logic            div_reg;
  logic            div_next;
  logic            en_reg;
  logic            en_next;

  // A load takes effect on the same edge, so the outputs computed at that
  // edge already follow the new ratio.
  always_comb begin
    sel_next = load ? load_sel : sel_reg;
    div_next = 1'b0;
    en_next  = 1'b0;
    if (sel_next != '0) begin
      div_next = level_bit(32'(cnt_nxt), 32'(sel_next));
      en_next  = run & ~sync_clr & boundary_match(32'(cnt_nxt), 32'(sel_next));
    end
  end

  // Register select and outputs; reset turns the channel off.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_reg <= '0;
      div_reg <= 1'b0;
      en_reg  <= 1'b0;
    end else begin
      sel_reg <= sel_next;
      div_reg <= div_next;
      en_reg  <= en_next;
    end
  end

  assign sel     = sel_reg;
  assign div_clk = div_reg;
  assign en_out  = en_reg;

endmodule

// File: rtl/clk_div_sched.sv
// Divided-clock scheduler: a shared free-running prescaler feeds NCH
// power-of-two dividers whose ratios are reprogrammed through a valid/ready
// port and only switch on a channel period boundary.
module clk_div_sched
  import clk_div_sched_pkg::*;
#(
  parameter int  NCH  = 4,
  parameter int  SELW = clk_div_sched_pkg::SELW,
  localparam int CNTW = (1 << SELW) - 1,
  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic            sync_clr,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [CHW-1:0]  cfg_ch,
  input  logic [SELW-1:0] cfg_sel,
  output logic            cfg_done,
  output logic [NCH-1:0]  div_clk,
  output logic [NCH-1:0]  en_out
);

  logic [CNTW-1:0] cnt_reg;
  logic [CNTW-1:0] cnt_next;

  cfg_state_t      state_reg;
  logic [CHW-1:0]  pend_ch_reg;
  logic [SELW-1:0] pend_sel_reg;
  logic            cfg_ready_reg;
  logic            cfg_done_reg;

  logic [SELW-1:0] chan_sel [NCH];
  logic [SELW-1:0] cur_sel;
  logic            pend_in_range;
  logic            safe;
  logic            apply;
  logic [NCH-1:0]  ch_load;

  // Next prescaler value; a synchronous clear beats run.
  always_comb begin
    if (sync_clr) begin
      cnt_next = '0;
    end else if (run) begin
      cnt_next = cnt_reg + 1'b1;
    end else begin
      cnt_next = cnt_reg;
    end
  end

  // Prescaler register; wraps naturally at 2^CNTW.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  // Look up the current ratio of the pending channel. An out-of-range channel
  // matches nothing and is treated as always safe, so it drains at once.
  always_comb begin
    cur_sel       = '0;
    pend_in_range = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (pend_ch_reg == CHW'(i)) begin
        cur_sel       = chan_sel[i];
        pend_in_range = 1'b1;
      end
    end
  end

  // A pending config may apply only where the channel cannot show a runt
  // phase: channel off, counter frozen or being cleared, or a period start.
  always_comb begin
    safe  = ~pend_in_range
          | (cur_sel == '0)
          | ~run
          | sync_clr
          | period_start(32'(cnt_next), 32'(cur_sel));
    apply = (state_reg == WAIT) & safe;
  end

  // Config handshake FSM with registered ready/done; only one request is in
  // flight, and accept never coincides with apply.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      pend_ch_reg   <= '0;
      pend_sel_reg  <= '0;
      cfg_ready_reg <= 1'b1;
      cfg_done_reg  <= 1'b0;
    end else begin
      cfg_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cfg_valid && cfg_ready_reg) begin
            pend_ch_reg   <= cfg_ch;
            pend_sel_reg  <= cfg_sel;
            state_reg     <= WAIT;
            cfg_ready_reg <= 1'b0;
          end
        end
        WAIT: begin
          if (apply) begin
            state_reg     <= IDLE;
            cfg_ready_reg <= 1'b1;
            cfg_done_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg     <= IDLE;
          cfg_ready_reg <= 1'b1;
        end
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
      assign ch_load[gi] = apply & (pend_ch_reg == CHW'(gi));

      clk_div_chan #(
        .SELW (SELW),
        .CNTW (CNTW)
      ) u_chan (
        .clk      (clk),
        .reset    (reset),
        .cnt_nxt  (cnt_next),
        .run      (run),
        .sync_clr (sync_clr),
        .load     (ch_load[gi]),
        .load_sel (pend_sel_reg),
        .sel      (chan_sel[gi]),
        .div_clk  (div_clk[gi]),
        .en_out   (en_out[gi])
      );
    end
  endgenerate

  assign cfg_ready = cfg_ready_reg;
  assign cfg_done  = cfg_done_reg;

endmodule

// File: tb/tb_clk_div_sched.sv
// Directed bench for clk_div_sched: a cycle model pushes expected outputs to
// a scoreboard queue as stimulus is driven; each sample pops and compares.
module tb_clk_div_sched;

  localparam int NCH  = 4;
  localparam int SELW = 3;
  localparam int CHW  = 2;
  localparam int CMOD = 128;

  logic            clk = 1'b0;
  logic            reset;
  logic            run;
  logic            sync_clr;
  logic            cfg_valid;
  logic            cfg_ready;
  logic [CHW-1:0]  cfg_ch;
  logic [SELW-1:0] cfg_sel;
  logic            cfg_done;
  logic [NCH-1:0]  div_clk;
  logic [NCH-1:0]  en_out;

  clk_div_sched #(
    .NCH  (NCH),
    .SELW (SELW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .sync_clr  (sync_clr),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_sel   (cfg_sel),
    .cfg_done  (cfg_done),
    .div_clk   (div_clk),
    .en_out    (en_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic           ready;
    logic           done;
    logic [NCH-1:0] div;
    logic [NCH-1:0] en;
  } exp_t;

  exp_t sb[$];

  int applied     = 0;
  int miscompares = 0;
  int cycle       = 0;

  // Reference model state
  int m_cnt;
  int m_sel [NCH];
  bit m_wait;
  int m_pch;
  int m_psel;

  // Observation statistics
  int en1_cnt, hi1_cnt, done_cnt;
  bit meas_en;
  int hi_len, min_hi;
  int rise;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    applied++;
    assert (obs === exp_v)
    else begin
      miscompares++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cycle, obs, exp_v);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step(output exp_t e);
    int  nxt, s_old, half;
    bit  apply;
    e = '0;
    if (reset) begin
      m_cnt  = 0;
      for (int i = 0; i < NCH; i++) m_sel[i] = 0;
      m_wait = 0;
      m_pch  = 0;
      m_psel = 0;
      e.ready = 1'b1;
      return;
    end
    nxt = sync_clr ? 0 : (run ? (m_cnt + 1) % CMOD : m_cnt);
    apply = 0;
    if (m_wait) begin
      s_old = (m_pch < NCH) ? m_sel[m_pch] : 0;
      apply = (m_pch >= NCH) || (s_old == 0) || !run || sync_clr || ((nxt % (1 << s_old)) == 0);
    end
    if (apply && m_pch < NCH) m_sel[m_pch] = m_psel;
    for (int i = 0; i < NCH; i++) begin
      if (m_sel[i] != 0) begin
        half      = 1 << (m_sel[i] - 1);
        e.div[i]  = ((nxt / half) % 2) == 1;
        e.en[i]   = run && !sync_clr && ((nxt % (2 * half)) == half);
      end
    end
    if (!m_wait) begin
      if (cfg_valid) begin
        m_wait = 1;
        m_pch  = int'(cfg_ch);
        m_psel = int'(cfg_sel);
      end
    end else if (apply) begin
      m_wait = 0;
    end
    e.ready = !m_wait;
    e.done  = apply;
    m_cnt   = nxt;
  endtask

  // One clock: predict, push, clock, pop, compare, update statistics.
  task automatic cyc();
    exp_t e, got;
    model_step(e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    cycle++;
    got = sb.pop_front();
    check("cfg_ready", 32'(cfg_ready), 32'(got.ready));
    check("cfg_done",  32'(cfg_done),  32'(got.done));
    check("div_clk",   32'(div_clk),   32'(got.div));
    check("en_out",    32'(en_out),    32'(got.en));
    if (cfg_done) begin
      done_cnt++;
      $display("cycle %0d: config applied, div_clk=%b en_out=%b", cycle, div_clk, en_out);
    end
    if (en_out[1]) en1_cnt++;
    if (div_clk[1]) hi1_cnt++;
    if (meas_en) begin
      if (div_clk[1]) begin
        hi_len++;
      end else if (hi_len > 0) begin
        if (hi_len < min_hi) min_hi = hi_len;
        hi_len = 0;
      end
    end
  endtask

  initial begin
    reset = 1'b1; run = 1'b1; sync_clr = 1'b0;
    cfg_valid = 1'b0; cfg_ch = '0; cfg_sel = '0;
    en1_cnt = 0; hi1_cnt = 0; done_cnt = 0;
    meas_en = 0; hi_len = 0; min_hi = 99; rise = -1;

    // Reset defaults with run held high
    repeat (3) cyc();
    check("reset_ready", 32'(cfg_ready), 32'd1);
    check("reset_div",   32'(div_clk),   32'd0);

    // Immediate apply: ch0 -> sel 1, ch1 -> sel 3 while frozen
    reset = 1'b0; run = 1'b0;
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_sel = 3'd1;
    cyc();
    cfg_ch = 2'd1; cfg_sel = 3'd3;
    cyc();
    cyc();
    cfg_valid = 1'b0;
    cyc();
    cyc();
    run = 1'b1;
    en1_cnt = 0; hi1_cnt = 0;
    repeat (16) cyc();
    check("ch1_high_cycles_16", 32'(hi1_cnt), 32'd8);
    check("ch1_strobes_16",     32'(en1_cnt), 32'd2);

    // Safe-boundary apply: ch1 sel 3 -> sel 2 just after a period start
    for (int k = 0; k < 16; k++) begin
      if ((m_cnt % 8) == 1) break;
      cyc();
    end
    done_cnt = 0; meas_en = 1; hi_len = 0; min_hi = 99;
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_sel = 3'd2;
    cyc();
    cfg_valid = 1'b0;
    repeat (20) cyc();
    meas_en = 0;
    check("boundary_done_count", 32'(done_cnt), 32'd1);
    check("no_runt_high_phase", 32'(min_hi >= 2), 32'd1);

    // Frozen counter: requests apply at the next edge
    run = 1'b0;
    cyc();
    cyc();
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_sel = 3'd3;
    cyc();
    cfg_ch = 2'd2; cfg_sel = 3'd4;
    cyc();
    cyc();
    cfg_valid = 1'b0;
    cyc();
    cyc();
    check("frozen_en", 32'(en_out), 32'd0);

    // sync_clr while pending: ch2 sel 4 -> sel 7
    run = 1'b1;
    repeat (5) cyc();
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_sel = 3'd7;
    cyc();
    cfg_valid = 1'b0;
    sync_clr = 1'b1;
    cyc();
    sync_clr = 1'b0;
    check("sync_clr_div", 32'(div_clk), 32'd0);
    check("sync_clr_en",  32'(en_out),  32'd0);
    check("sync_clr_done", 32'(cfg_done), 32'd1);
    rise = -1;
    for (int k = 1; k <= 100; k++) begin
      cyc();
      if (div_clk[2]) begin
        rise = k;
        break;
      end
    end
    check("ch2_first_rise", 32'(rise), 32'd64);

    // Reset in WAIT: accepted request is discarded
    cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_sel = 3'd2;
    cyc();
    cfg_valid = 1'b0;
    reset = 1'b1;
    done_cnt = 0;
    cyc();
    cyc();
    reset = 1'b0;
    repeat (8) cyc();
    check("reset_wait_no_done", 32'(done_cnt), 32'd0);
    check("reset_wait_ch3_off", 32'(div_clk[3]), 32'd0);
    check("reset_wait_ready",   32'(cfg_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/clk_div_sched.md
# clk_div_sched

Synchronous divided-clock scheduler. One shared free-running prescaler counter drives NCH output channels. Each channel produces a 50% duty divided level and a one-cycle enable strobe at a programmable power-of-two ratio. Ratios are reprogrammed through a valid/ready handshake and take effect only at a channel's period boundary, so no output ever shows a runt phase. It sequences the divider chain for downstream logic, replacing ripple-clocked toggle stages with clock enables in the single clk domain.

## Interface
Parameters:
- NCH, 4, number of output channels (1..8)
- SELW, 3, ratio-select width; counter width CNTW = 2^SELW - 1 (7)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous active-high reset
- run  in  1  counter advances when 1; frozen when 0
- sync_clr  in  1  synchronous restart of counter and phases
- cfg_valid  in  1  config request valid
- cfg_ready  out  1  block can accept a config request
- cfg_ch  in  $clog2(NCH) (min 1)  target channel
- cfg_sel  in  SELW  ratio select: 0 = channel off, s = 1..CNTW gives divide by 2^s
- cfg_done  out  1  one-cycle pulse when a config takes effect
- div_clk  out  NCH  divided level per channel, registered
- en_out  out  NCH  one-cycle strobe per channel period, registered

## Operation
- cnt (CNTW bits): cnt_nxt = sync_clr ? 0 : run ? cnt+1 (wraps 2^CNTW-1 -> 0) : cnt.
- Per channel i with select s_i:
  - s_i = 0: div_clk[i] <= 0 and en_out[i] <= 0.
  - Otherwise: div_clk[i] <= cnt_nxt[s_i-1].
  - en_out[i] <= 1 only when run = 1, sync_clr = 0 and cnt_nxt[s_i-1:0] == 2^(s_i-1). The strobe coincides with the first cycle div_clk[i] is 1.
- Config FSM:
  - IDLE: cfg_ready = 1. A transfer occurs when cfg_valid & cfg_ready; capture ch and sel, then go to WAIT.
  - WAIT: cfg_ready = 0. Apply at the first edge where the safe condition holds, then return to IDLE.
- Safe condition for pending channel c: s_c == 0, or run == 0, or sync_clr == 1, or cnt_nxt[s_c-1:0] == 0.
- On apply: s_c <= pending sel; cfg_done <= 1 for one cycle. The outputs computed at that same edge already use the new sel.
- A cfg_ch value of NCH or higher is accepted and then dropped: one cfg_done pulse, no state change.
- Only one request is in flight. cfg_valid may stay high, and the next request is accepted in the cycle after return to IDLE.

## Timing
- Reset values: cnt = 0, all s_i = 0, div_clk = 0, en_out = 0, cfg_done = 0, FSM = IDLE (cfg_ready = 1).
- Output latency: one cycle from cnt_nxt. With run held high, div_clk[i] has period 2^s_i cycles, high for 2^(s_i-1) cycles.
- Config latency:
  - Transfer at edge k.
  - Apply at the earliest edge k+n (n ≥ 1) meeting the safe condition.
  - Worst case n = 2^s_old.
  - cfg_done is high in the cycle after apply.
- Accept and apply never occur at the same edge. The FSM is back in IDLE (cfg_ready = 1) in the cycle after apply.
- sync_clr during WAIT: the pending config applies at that edge. Counter, div_clk and en_out are all 0 in the next cycle.
- sync_clr and run together: sync_clr wins.
- reset mid-WAIT: the pending request is discarded with no cfg_done pulse. reset overrides every other input.

## Structure
- Package clk_div_sched_pkg holds:
  - SELW and CNTW
  - the FSM state enum (IDLE, WAIT)
  - a function computing the period-boundary match from (cnt_nxt, sel)
- Sub-module clk_div_chan, instantiated NCH times. It holds s_i, div_clk[i] and en_out[i], and takes cnt_nxt, run, sync_clr and an apply/sel load port.
- The top level holds cnt, the FSM, the pending registers and the handshake.

## Test plan
- **Reset defaults:** Assert reset 3 cycles with run = 1 -> cnt = 0, div_clk = 0, en_out = 0, cfg_ready = 1, cfg_done = 0.
- **Immediate apply:** From reset, set ch 0 to sel 1 and ch 1 to sel 3, then run = 1.
  - Ch 0 was off, so apply is immediate and cfg_done pulses one cycle after apply.
  - div_clk[0] toggles every cycle.
  - div_clk[1] has period 8, high 4 cycles.
  - en_out[1] is high once per 8 cycles, on div_clk[1] rising.
- **Safe-boundary apply:** With ch 1 at sel 3, request sel 2 just after a period start.
  - cfg_ready stays 0 until the next cnt_nxt[2:0] == 0 edge.
  - No high phase shorter than 2 cycles appears on div_clk[1].
  - cfg_done fires once.
- **Frozen counter:** Set run = 0 mid-period -> outputs hold, en_out = 0. A config request applies at the next edge.
- **sync_clr while pending:** Pend ch 2 to sel 7 and pulse sync_clr -> apply at that edge. All outputs are 0 the next cycle, and div_clk[2] first rises 64 cycles after run resumes.
- **Reset in WAIT:** Accept a request, then assert reset before apply -> no cfg_done pulse, the channel stays at sel 0, and cfg_ready = 1 after reset.
